// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared states, opcode/funct3 encodings and ALU op codes for the multicycle sequencer.
package ctrl_pkg;
   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_e;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_AND = 3'b111;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
endpackage

// File: rtl/imm_gen.sv
// imm_gen: sign-extended immediate from the instruction fields; S for stores, B for branches, I otherwise.
// The word is split so only bits that feed an immediate or the format select enter the block.
module imm_gen
   import ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [11:0]           hi_i,
   input  logic [11:0]           lo_i,
   output logic [DATA_WIDTH-1:0] imm_o
);
   logic [6:0] opc;
   assign opc = lo_i[6:0];
   always_comb
      imm_o = (opc == OPC_STORE)  ? {{(DATA_WIDTH-12){hi_i[11]}}, hi_i[11:5], lo_i[11:7]} :
              (opc == OPC_BRANCH) ? {{(DATA_WIDTH-13){hi_i[11]}}, hi_i[11], lo_i[7], hi_i[10:5], lo_i[11:8], 1'b0} :
                                    {{(DATA_WIDTH-12){hi_i[11]}}, hi_i};
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for the reduced RV32 datapath.
// Owns the PC, decodes the latched instruction and halts in TRAP on anything illegal.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int                    DATA_WIDTH    = 32,
   parameter int                    ADDRESS_WIDTH = 5,
   parameter int                    ALUctrl_WIDTH = 3,
   parameter logic [DATA_WIDTH-1:0] PC_RESET      = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     instr_req,
   input  logic                     instr_valid,
   input  logic [DATA_WIDTH-1:0]    instr,
   output logic [DATA_WIDTH-1:0]    pc,
   input  logic                     Zero,
   output logic [DATA_WIDTH-1:0]    ImmOp,
   output logic                     RegWrite,
   output logic [ALUctrl_WIDTH-1:0] ALUctrl,
   output logic                     ALUsrc,
   output logic [ADDRESS_WIDTH-1:0] rs1,
   output logic [ADDRESS_WIDTH-1:0] rs2,
   output logic [ADDRESS_WIDTH-1:0] rd,
   output logic                     MemWrite,
   output logic                     ResultSrc,
   output logic                     retire,
   output logic                     trap
);
   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d, instr_q, instr_d;
   logic [6:0]            opc;
   logic [2:0]            f3;
   logic                  is_op, is_imm, is_ld, is_st, is_br, legal, taken;
   assign opc = instr_q[6:0];
   assign f3  = instr_q[14:12];
   imm_gen #(.DATA_WIDTH(DATA_WIDTH)) u_imm (
      .hi_i (instr_q[31:20]),
      .lo_i (instr_q[11:0]),
      .imm_o(ImmOp)
   );
   always_comb begin
      is_op  = (opc == OPC_OP) && (f3 == F3_ADD || f3 == F3_AND || f3 == F3_OR);
      is_imm = (opc == OPC_OPIMM) && (f3 == F3_ADD);
      is_ld  = (opc == OPC_LOAD) && (f3 == F3_LW);
      is_st  = (opc == OPC_STORE) && (f3 == F3_LW);
      is_br  = (opc == OPC_BRANCH) && (f3 == F3_BEQ || f3 == F3_BNE);
      legal  = is_op | is_imm | is_ld | is_st | is_br;
      taken  = f3[0] ? ~Zero : Zero;
   end
   // Decoded controls depend only on the latched word, so they stay put from DECODE through WB.
   assign ALUctrl   = is_br ? ALU_SUB : !is_op ? ALU_ADD : (f3 == F3_AND) ? ALU_AND :
                      (f3 == F3_OR) ? ALU_OR : instr_q[30] ? ALU_SUB : ALU_ADD;
   assign ALUsrc    = is_imm | is_ld | is_st;
   assign ResultSrc = is_ld;
   assign rs1       = instr_q[19:15];
   assign rs2       = instr_q[24:20];
   assign rd        = instr_q[11:7];
   assign pc        = pc_q;
   assign instr_req = (state_q == S_FETCH);
   assign trap      = (state_q == S_TRAP);
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      retire   = 1'b0;
      case (state_q)
         S_FETCH: if (instr_valid) begin
            instr_d = instr;
            state_d = S_DECODE;
         end
         S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
         S_EXEC: if (is_br) begin
            pc_d    = pc_q + (taken ? ImmOp : DATA_WIDTH'(4));
            retire  = 1'b1;
            state_d = S_FETCH;
         end else begin
            state_d = (is_ld | is_st) ? S_MEM : S_WB;
         end
         S_MEM: if (is_st) begin
            MemWrite = 1'b1;
            pc_d     = pc_q + DATA_WIDTH'(4);
            retire   = 1'b1;
            state_d  = S_FETCH;
         end else begin
            state_d = S_WB;
         end
         S_WB: begin
            RegWrite = (rd != '0);
            pc_d     = pc_q + DATA_WIDTH'(4);
            retire   = 1'b1;
            state_d  = S_FETCH;
         end
         default: state_d = S_TRAP;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= PC_RESET;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table of instructions with hand-computed controls, cycle counts and PCs,
// plus directed sequences for FETCH stalls, reset mid-instruction and illegal-instruction trap.
module tb_multicycle_ctrl;
   logic        clk = 1'b0, rst = 1'b1, instr_valid = 1'b0, Zero = 1'b0;
   logic [31:0] instr = '0;
   logic        instr_req, RegWrite, ALUsrc, MemWrite, ResultSrc, retire, trap;
   logic [31:0] pc, ImmOp;
   logic [2:0]  ALUctrl;
   logic [4:0]  rs1, rs2, rd;
   int          n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   multicycle_ctrl dut (
      .clk(clk), .rst(rst), .instr_req(instr_req), .instr_valid(instr_valid), .instr(instr),
      .pc(pc), .Zero(Zero), .ImmOp(ImmOp), .RegWrite(RegWrite), .ALUctrl(ALUctrl),
      .ALUsrc(ALUsrc), .rs1(rs1), .rs2(rs2), .rd(rd), .MemWrite(MemWrite),
      .ResultSrc(ResultSrc), .retire(retire), .trap(trap)
   );

   typedef struct {
      logic [31:0] instr;
      logic        zero;
      int          cyc;
      logic [31:0] pc_after, imm;
      logic [2:0]  alu;
      logic        src;
      logic [4:0]  rs1, rs2, rd;
      int          rw, mw;
      logic        rsrc;
   } vec_t;
   vec_t tbl[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Entered at a falling edge with the DUT in FETCH; leaves at the falling edge of the next FETCH.
   task automatic run(input vec_t v, input int idx);
      int n = 1, rw = 0, mw = 0;
      string tag = $sformatf("v%0d", idx);
      chk({tag, ".req"}, instr_req, 1);
      instr_valid = 1'b1;
      instr       = v.instr;
      Zero        = v.zero;
      @(negedge clk);
      instr_valid = 1'b0;
      n = 2;
      chk({tag, ".dec_imm"}, ImmOp, v.imm);
      chk({tag, ".dec_alu"}, 32'(ALUctrl), 32'(v.alu));
      rw += int'(RegWrite);
      mw += int'(MemWrite);
      while (!retire && n < 8) begin
         @(negedge clk);
         n++;
         rw += int'(RegWrite);
         mw += int'(MemWrite);
      end
      chk({tag, ".cycles"}, 32'(n), 32'(v.cyc));
      chk({tag, ".imm"}, ImmOp, v.imm);
      chk({tag, ".alu"}, 32'(ALUctrl), 32'(v.alu));
      chk({tag, ".alusrc"}, 32'(ALUsrc), 32'(v.src));
      chk({tag, ".rs1"}, 32'(rs1), 32'(v.rs1));
      chk({tag, ".rs2"}, 32'(rs2), 32'(v.rs2));
      chk({tag, ".rd"}, 32'(rd), 32'(v.rd));
      chk({tag, ".rsrc"}, 32'(ResultSrc), 32'(v.rsrc));
      @(negedge clk);
      chk({tag, ".regwrite_pulses"}, 32'(rw), 32'(v.rw));
      chk({tag, ".memwrite_pulses"}, 32'(mw), 32'(v.mw));
      chk({tag, ".pc"}, pc, v.pc_after);
      chk({tag, ".req_after"}, instr_req, 1);
   endtask

   task automatic trap_seq(input logic [31:0] bad, input string tag);
      instr_valid = 1'b1;
      instr       = bad;
      @(negedge clk);
      instr_valid = 1'b0;
      chk({tag, ".trap_in_decode"}, trap, 0);
      for (int k = 0; k < 4; k++) begin
         instr_valid = 1'b1;
         instr       = 32'h00500513;
         @(negedge clk);
         chk({tag, ".trap"}, trap, 1);
         chk({tag, ".req"}, instr_req, 0);
         chk({tag, ".pc"}, pc, 0);
         chk({tag, ".strobes"}, {29'd0, RegWrite, MemWrite, retire}, 0);
      end
      instr_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk({tag, ".trap_cleared"}, trap, 0);
      chk({tag, ".req_restored"}, instr_req, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{32'h00500513, 1'b0, 4, 32'h04, 32'h5,        3'd0, 1'b1, 5'd0,  5'd5,  5'd10, 1, 0, 1'b0};
      tbl[1] = '{32'h00A02423, 1'b0, 4, 32'h08, 32'h8,        3'd0, 1'b1, 5'd0,  5'd10, 5'd8,  0, 1, 1'b0};
      tbl[2] = '{32'h00802583, 1'b0, 5, 32'h0C, 32'h8,        3'd0, 1'b1, 5'd0,  5'd8,  5'd11, 1, 0, 1'b1};
      tbl[3] = '{32'h00208033, 1'b0, 4, 32'h10, 32'h2,        3'd0, 1'b0, 5'd1,  5'd2,  5'd0,  0, 0, 1'b0};
      tbl[4] = '{32'hFE059CE3, 1'b0, 3, 32'h08, 32'hFFFFFFF8, 3'd1, 1'b0, 5'd11, 5'd0,  5'd25, 0, 0, 1'b0};
      tbl[5] = '{32'h007372B3, 1'b0, 4, 32'h0C, 32'h7,        3'd2, 1'b0, 5'd6,  5'd7,  5'd5,  1, 0, 1'b0};
      tbl[6] = '{32'h403100B3, 1'b0, 4, 32'h10, 32'h403,      3'd1, 1'b0, 5'd2,  5'd3,  5'd1,  1, 0, 1'b0};
      tbl[7] = '{32'hFE059CE3, 1'b1, 3, 32'h14, 32'hFFFFFFF8, 3'd1, 1'b0, 5'd11, 5'd0,  5'd25, 0, 0, 1'b0};
      tbl[8] = '{32'h0062E233, 1'b0, 4, 32'h18, 32'h6,        3'd3, 1'b0, 5'd5,  5'd6,  5'd4,  1, 0, 1'b0};
      tbl[9] = '{32'hFFF00093, 1'b0, 4, 32'h1C, 32'hFFFFFFFF, 3'd0, 1'b1, 5'd0,  5'd31, 5'd1,  1, 0, 1'b0};

      repeat (2) @(negedge clk);
      chk("rst.pc", pc, 0);
      chk("rst.req", instr_req, 1);
      chk("rst.trap", trap, 0);
      chk("rst.strobes", {29'd0, RegWrite, MemWrite, retire}, 0);
      rst = 1'b0;

      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall.req", instr_req, 1);
         chk("stall.pc", pc, 0);
         chk("stall.retire", retire, 0);
      end

      for (int i = 0; i < 10; i++) run(tbl[i], i);

      instr_valid = 1'b1;
      instr       = 32'h00802583;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midrst.pc", pc, 0);
      chk("midrst.req", instr_req, 1);
      chk("midrst.strobes", {29'd0, RegWrite, MemWrite, retire}, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst.pc_after", pc, 0);
      chk("midrst.req_after", instr_req, 1);
      chk("midrst.strobes_after", {29'd0, RegWrite, MemWrite, retire}, 0);

      trap_seq(32'hFFFFFFFF, "trap_ones");
      trap_seq(32'h00101093, "trap_slli");
      run(tbl[0], 10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
